// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with run-time baud divisor,
// optional parity, 1..2 stop bits, valid/ready output handshake and
// parity / framing / break / overrun reporting.
//
// Build option: define UART_RX_MAJORITY_EN to take a 2-of-3 majority vote of
// the synchronised line at mid-1, mid and mid+1 of every bit; the decision is
// registered at mid+1. Without it a single sample is taken at mid.

module uart_rx_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx,
    input  logic [DIV_W-1:0]     i_baud_div,
    input  logic                 i_rx_ready,
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_framing_err,
    output logic                 o_break_det,
    output logic                 o_overrun_err
);

    // Bit counter must reach DATA_BITS-1 (data) and STOP_BITS-1 (stop).
    localparam int               BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } stateT;

    stateT                  r_state;
    logic                   r_rxMeta;
    logic                   r_rxSync;
    logic                   r_armed;
    logic [DIV_W-1:0]       r_div;
    logic [DIV_W-1:0]       r_count;
    logic [BIT_CNT_W-1:0]   r_bitCount;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parityBit;
    logic                   r_stopErr;
    logic                   r_anyHigh;
    logic                   r_frameDone;
    logic [DATA_BITS-1:0]   r_doneData;
    logic                   r_doneParErr;
    logic                   r_doneFrameErr;
    logic                   r_doneBreak;

    logic [DIV_W-1:0]       w_divClamped;
    logic [DIV_W-1:0]       w_midCount;
    logic                   w_atMid;
    logic                   w_decide;
    logic                   w_bit;
    logic                   w_parityErr;
    logic                   w_handshake;

    assign w_divClamped = (i_baud_div < MIN_DIV) ? MIN_DIV : i_baud_div;
    // The start bit is judged half a bit in; every later bit a full bit after the previous sample.
    assign w_midCount   = (r_state == S_START) ? (r_div >> 1) : (r_div - DIV_W'(1));
    assign w_atMid      = (r_state != S_IDLE) && (r_count == w_midCount);
    assign w_handshake  = o_rx_valid & i_rx_ready;

    // Two-flop synchroniser; resets low so the line must genuinely read high before arming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxMeta <= 1'b0;
            r_rxSync <= 1'b0;
        end else begin
            r_rxMeta <= i_rx;
            r_rxSync <= r_rxMeta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_rxPrev;
    logic r_s0;
    logic r_s1;
    logic r_pending;

    // Capture the mid-1 and mid samples; the vote completes with the live sample one clock later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxPrev  <= 1'b0;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_rxPrev  <= r_rxSync;
            r_pending <= w_atMid;
            if (w_atMid) begin
                r_s0 <= r_rxPrev;
                r_s1 <= r_rxSync;
            end
        end
    end

    assign w_decide = r_pending;
    assign w_bit    = (r_s0 & r_s1) | (r_s0 & r_rxSync) | (r_s1 & r_rxSync);
`else
    assign w_decide = w_atMid;
    assign w_bit    = r_rxSync;
`endif

    // Parity check over the received word and parity bit; constant 0 when parity is off.
    always_comb begin
        w_parityErr = 1'b0;
        if (PARITY == 1) begin
            w_parityErr = ^{r_shift, r_parityBit};
        end else if (PARITY == 2) begin
            w_parityErr = ~(^{r_shift, r_parityBit});
        end
    end

    // Bit timer: restarts at every sample point so samples stay exactly one bit apart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_state == S_IDLE || w_atMid) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DIV_W'(1);
        end
    end

    // Frame FSM: walks start, data, parity and stop bits and latches the finished frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_armed        <= 1'b0;
            r_div          <= MIN_DIV;
            r_bitCount     <= '0;
            r_shift        <= '0;
            r_parityBit    <= 1'b0;
            r_stopErr      <= 1'b0;
            r_anyHigh      <= 1'b0;
            r_frameDone    <= 1'b0;
            r_doneData     <= '0;
            r_doneParErr   <= 1'b0;
            r_doneFrameErr <= 1'b0;
            r_doneBreak    <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_rxSync) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state    <= S_START;
                        r_div      <= w_divClamped;
                        r_bitCount <= '0;
                        r_stopErr  <= 1'b0;
                        r_anyHigh  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_decide) begin
                        r_state <= w_bit ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_anyHigh <= r_anyHigh | w_bit;
                        if (r_bitCount == BIT_CNT_W'(DATA_BITS - 1)) begin
                            r_bitCount <= '0;
                            r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bitCount <= r_bitCount + BIT_CNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_parityBit <= w_bit;
                        r_anyHigh   <= r_anyHigh | w_bit;
                        r_state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        if (r_bitCount == BIT_CNT_W'(STOP_BITS - 1)) begin
                            r_state        <= S_IDLE;
                            r_frameDone    <= 1'b1;
                            r_doneData     <= r_shift;
                            r_doneParErr   <= w_parityErr;
                            r_doneFrameErr <= r_stopErr | ~w_bit;
                            r_doneBreak    <= ~(r_anyHigh | w_bit);
                            if (r_stopErr | ~w_bit) begin
                                r_armed <= 1'b0;
                            end
                        end else begin
                            r_bitCount <= r_bitCount + BIT_CNT_W'(1);
                            r_stopErr  <= r_stopErr | ~w_bit;
                            r_anyHigh  <= r_anyHigh | w_bit;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output handshake: a completed frame loads unless an unread frame is still held (overrun).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rx_valid    <= 1'b0;
            o_rx_data     <= '0;
            o_parity_err  <= 1'b0;
            o_framing_err <= 1'b0;
            o_break_det   <= 1'b0;
            o_overrun_err <= 1'b0;
        end else if (r_frameDone && (!o_rx_valid || w_handshake)) begin
            o_rx_valid    <= 1'b1;
            o_rx_data     <= r_doneData;
            o_parity_err  <= r_doneParErr;
            o_framing_err <= r_doneFrameErr;
            o_break_det   <= r_doneBreak;
            if (w_handshake) begin
                o_overrun_err <= 1'b0;
            end
        end else if (r_frameDone) begin
            o_overrun_err <= 1'b1;
        end else if (w_handshake) begin
            o_rx_valid    <= 1'b0;
            o_overrun_err <= 1'b0;
        end
    end

endmodule
